addr_lookup: RTL and testbench

Sequential probe engine that resolves a 64-bit address to the hash-table slot holding its key. It sits on the read side of the address-mapping table, opposite the insert path. For each request it evaluates up to NUM_HASH_FUNC multiply-shift hashes in order, reads the addressed bucket, and compares tags. It returns hit/miss plus the function, bucket and slot that matched.

---
 rtl/addr_lookup.sv | 217 +++++++++++++++++++++
 tb/tb_addr_lookup.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_lookup.sv
// addr_lookup
// Sequential probe engine that resolves an address to the hash-table slot
// holding its key. For each request it walks the configured multiply-shift
// hash functions in order, reads one bucket per probe, and compares the
// stored tags against the low address bits.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   cfg_we/cfg_ready      coefficient/bucket-count write, accepted only in IDLE
//   cfg_sel               hash function written
//   cfg_coe_a/cfg_coe_b   multiplier / addend for that function
//   cfg_lg_num_buckets    log2 of active bucket count (written on every cfg_we)
//   req_valid/req_ready   lookup request handshake, req_addr is the key
//   tbl_rd_en/bucket      one-cycle read pulse per probe
//   tbl_rd_data           bucket contents, one cycle after tbl_rd_en
//   rsp_valid/rsp_ready   response handshake
//   rsp_hit/func/bucket/slot  lookup result
//   stat_hits/stat_misses saturating counters of completed responses
//
// Build option
//   ADDR_LOOKUP_STATS_EN  when defined, builds the statistics counters;
//                         otherwise stat_hits/stat_misses are tied to 0.

module addr_lookup #(
   parameter int ADDR_WIDTH     = 64,
   parameter int NUM_HASH_FUNC  = 2,
   parameter int SLOTS          = 4,
   parameter int TAG_WIDTH      = 11,
   parameter int LG_MAX_BUCKETS = 10
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  cfg_we,
   output logic                                  cfg_ready,
   input  logic [1:0]                            cfg_sel,
   input  logic [ADDR_WIDTH-1:0]                 cfg_coe_a,
   input  logic [ADDR_WIDTH-1:0]                 cfg_coe_b,
   input  logic [$clog2(LG_MAX_BUCKETS+1)-1:0]   cfg_lg_num_buckets,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [ADDR_WIDTH-1:0]                 req_addr,
   output logic                                  tbl_rd_en,
   output logic [LG_MAX_BUCKETS-1:0]             tbl_rd_bucket,
   input  logic [SLOTS*(TAG_WIDTH+1)-1:0]        tbl_rd_data,
   output logic                                  rsp_valid,
   input  logic                                  rsp_ready,
   output logic                                  rsp_hit,
   output logic [1:0]                            rsp_func,
   output logic [LG_MAX_BUCKETS-1:0]             rsp_bucket,
   output logic [$clog2(SLOTS)-1:0]              rsp_slot,
   output logic [31:0]                           stat_hits,
   output logic [31:0]                           stat_misses
);

   localparam int ENTRY_W  = TAG_WIDTH + 1;
   localparam int SLOT_W   = $clog2(SLOTS);
   localparam int LGN_W    = $clog2(LG_MAX_BUCKETS + 1);
   localparam int SH_W     = $clog2(ADDR_WIDTH + 1);
   // Coefficient storage is always sized for the full 2-bit function index
   // so indexing by func_q never selects outside the array.
   localparam int MAX_FUNC = 4;

   typedef enum logic [2:0] {IDLE, HASH, READ, CMP, RESP} state_t;

   state_t                    state, state_next;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [1:0]                func_q;
   logic [LG_MAX_BUCKETS-1:0] hash_q;
   logic [LG_MAX_BUCKETS-1:0] hash_next;
   logic [ADDR_WIDTH-1:0]     coe_a_q [MAX_FUNC];
   logic [ADDR_WIDTH-1:0]     coe_b_q [MAX_FUNC];
   logic [LGN_W-1:0]          lg_q;
   logic [ADDR_WIDTH-1:0]     prod;
   logic [SH_W-1:0]           shamt;
   logic                      match_found;
   logic [SLOT_W-1:0]         match_slot;
   logic                      last_func;
   logic                      cfg_write;

   assign cfg_ready     = (state == IDLE);
   assign req_ready     = (state == IDLE);
   assign tbl_rd_en     = (state == READ);
   assign tbl_rd_bucket = hash_q;
   assign rsp_valid     = (state == RESP);
   assign last_func     = (func_q == 2'(NUM_HASH_FUNC - 1));
   assign cfg_write     = cfg_we && (state == IDLE);

   // Multiply-shift hash of the latched address with the current function's
   // coefficients; keeps the top lg bits of the 64-bit wrapped result.
   always_comb begin
      prod      = coe_a_q[func_q] * addr_q + coe_b_q[func_q];
      shamt     = SH_W'(ADDR_WIDTH) - SH_W'(lg_q);
      hash_next = '0;
      if (lg_q != '0) begin
         hash_next = LG_MAX_BUCKETS'(prod >> shamt);
      end
   end

   // Tag compare across the bucket; the lowest matching slot wins.
   always_comb begin
      match_found = 1'b0;
      match_slot  = '0;
      for (int s = 0; s < SLOTS; s++) begin
         if (!match_found && tbl_rd_data[s*ENTRY_W + TAG_WIDTH] &&
             tbl_rd_data[s*ENTRY_W +: TAG_WIDTH] == addr_q[TAG_WIDTH-1:0]) begin
            match_found = 1'b1;
            match_slot  = SLOT_W'(s);
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: one HASH/READ/CMP pass per hash function until a hit or
   // the last function has been probed.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (req_valid) state_next = HASH;
         HASH: state_next = READ;
         READ: state_next = CMP;
         CMP:  state_next = (match_found || last_func) ? RESP : HASH;
         RESP: if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Configuration registers. Writes land only in IDLE, so a request
   // accepted in the same cycle already sees the new values in HASH.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int f = 0; f < MAX_FUNC; f++) begin
            coe_a_q[f] <= ADDR_WIDTH'(1);
            coe_b_q[f] <= '0;
         end
         lg_q <= LGN_W'(LG_MAX_BUCKETS);
      end else if (cfg_write) begin
         if (int'(cfg_sel) < NUM_HASH_FUNC) begin
            coe_a_q[cfg_sel] <= cfg_coe_a;
            coe_b_q[cfg_sel] <= cfg_coe_b;
         end
         lg_q <= cfg_lg_num_buckets;
      end
   end

   // Lookup datapath: latch the request, register each probe's hash, and
   // capture the response fields when the compare resolves.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         func_q     <= '0;
         hash_q     <= '0;
         rsp_hit    <= 1'b0;
         rsp_func   <= '0;
         rsp_bucket <= '0;
         rsp_slot   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  func_q <= '0;
               end
            end
            HASH: hash_q <= hash_next;
            CMP: begin
               if (match_found) begin
                  rsp_hit    <= 1'b1;
                  rsp_func   <= func_q;
                  rsp_bucket <= hash_q;
                  rsp_slot   <= match_slot;
               end else if (last_func) begin
                  rsp_hit    <= 1'b0;
                  rsp_func   <= func_q;
                  rsp_bucket <= hash_q;
                  rsp_slot   <= '0;
               end else begin
                  func_q <= func_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ADDR_LOOKUP_STATS_EN
   logic [31:0] hits_q, misses_q;

   // Saturating hit/miss counters, bumped on each completed response.
   always_ff @(posedge clk) begin
      if (reset) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else if (rsp_valid && rsp_ready) begin
         if (rsp_hit) begin
            if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
         end else begin
            if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
         end
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`else
   assign stat_hits   = '0;
   assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_addr_lookup.sv
// tb_addr_lookup
// Directed bench for addr_lookup. A behavioural table answers reads one
// cycle after tbl_rd_en and logs every bucket read; expected results are
// worked out by hand from the multiply-shift hash of 64'hAAAAAAAABBBBBBBB
// (bucket 682 with default coefficients, 938 with coe_b = 64'h4000...,
// tag 11'h3BB).

module tb_addr_lookup;

   localparam logic [63:0] ADDR_A = 64'hAAAA_AAAA_BBBB_BBBB;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic        cfg_ready;
   logic [1:0]  cfg_sel;
   logic [63:0] cfg_coe_a, cfg_coe_b;
   logic [3:0]  cfg_lg_num_buckets;
   logic        req_valid, req_ready;
   logic [63:0] req_addr;
   logic        tbl_rd_en;
   logic [9:0]  tbl_rd_bucket;
   logic [47:0] tbl_rd_data = '0;
   logic        rsp_valid, rsp_ready, rsp_hit;
   logic [1:0]  rsp_func;
   logic [9:0]  rsp_bucket;
   logic [1:0]  rsp_slot;
   logic [31:0] stat_hits, stat_misses;

   logic [47:0] tbl_mem [0:1023];
   logic [9:0]  rd_log  [0:63];
   int          rd_count = 0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   addr_lookup dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
      .cfg_coe_a(cfg_coe_a), .cfg_coe_b(cfg_coe_b),
      .cfg_lg_num_buckets(cfg_lg_num_buckets),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .tbl_rd_en(tbl_rd_en), .tbl_rd_bucket(tbl_rd_bucket),
      .tbl_rd_data(tbl_rd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
      .rsp_func(rsp_func), .rsp_bucket(rsp_bucket), .rsp_slot(rsp_slot),
      .stat_hits(stat_hits), .stat_misses(stat_misses)
   );

   // Table model: one-cycle read latency, plus a log of requested buckets.
   always @(posedge clk) begin
      if (tbl_rd_en) begin
         tbl_rd_data               <= tbl_mem[tbl_rd_bucket];
         rd_log[rd_count % 64]     <= tbl_rd_bucket;
         rd_count                  <= rd_count + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic configure(input logic [1:0] sel, input logic [63:0] a,
                            input logic [63:0] b, input logic [3:0] lg);
      @(negedge clk);
      cfg_we = 1'b1; cfg_sel = sel; cfg_coe_a = a; cfg_coe_b = b;
      cfg_lg_num_buckets = lg;
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Issue one request and return at the negedge where rsp_valid is seen.
   // lat counts cycles after the accepting edge (1 = HASH). Optionally
   // fires a config write while the engine is in READ.
   task automatic applyStimulus(input logic [63:0] addr, input bit cfg_in_read,
                                output int lat, output int base,
                                output logic rd2_en, output logic [9:0] rd2_bucket);
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = addr;
      base      = rd_count;
      @(posedge clk);
      @(negedge clk);
      req_valid  = 1'b0;
      lat        = 1;
      rd2_en     = 1'b0;
      rd2_bucket = '0;
      while (!rsp_valid && lat < 40) begin
         if (lat == 2) begin
            rd2_en     = tbl_rd_en;
            rd2_bucket = tbl_rd_bucket;
            if (cfg_in_read) begin
               checkOutput("cfg_ready_busy", 64'(cfg_ready), 64'd0);
               cfg_we = 1'b1; cfg_sel = 2'd1; cfg_coe_a = 64'd1;
               cfg_coe_b = 64'd0; cfg_lg_num_buckets = 4'd10;
            end
         end
         if (lat == 3) cfg_we = 1'b0;
         @(negedge clk);
         lat++;
      end
      cfg_we = 1'b0;
      if (!rsp_valid) checkOutput("rsp_timeout", 64'd0, 64'd1);
   endtask

   task automatic completeResp();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int          lat, base;
      logic        e2;
      logic [9:0]  b2;
      logic        seen_valid;

      reset = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_coe_a = '0; cfg_coe_b = '0;
      cfg_lg_num_buckets = '0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
      for (int i = 0; i < 1024; i++) tbl_mem[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      checkOutput("reset_ctrl", 64'({cfg_ready, req_ready, rsp_valid, tbl_rd_en, rsp_hit}),
                  64'b11000);
      checkOutput("reset_rsp", 64'({rsp_func, rsp_bucket, rsp_slot}), 64'd0);
      checkOutput("reset_stats", {stat_hits, stat_misses}, 64'd0);

      // First-function hit in slot 2 of bucket 682.
      tbl_mem[682] = {12'h000, 12'hBBB, 12'h000, 12'h000};
      applyStimulus(ADDR_A, 1'b0, lat, base, e2, b2);
      checkOutput("t1_lat", 64'(lat), 64'd4);
      checkOutput("t1_rd_at2", 64'({e2, b2}), 64'({1'b1, 10'd682}));
      checkOutput("t1_rsp", 64'({rsp_hit, rsp_func, rsp_bucket, rsp_slot}),
                  64'({1'b1, 2'd0, 10'd682, 2'd2}));
      checkOutput("t1_nreads", 64'(rd_count - base), 64'd1);
      completeResp();
      checkOutput("t1_idle", 64'({req_ready, rsp_valid}), 64'b10);

      // Second-function hit in bucket 938 slot 0.
      tbl_mem[682] = '0;
      tbl_mem[938] = {36'h0, 12'hBBB};
      configure(2'd1, 64'd1, 64'h4000_0000_0000_0000, 4'd10);
      applyStimulus(ADDR_A, 1'b0, lat, base, e2, b2);
      checkOutput("t2_lat", 64'(lat), 64'd7);
      checkOutput("t2_rd0", 64'(rd_log[base % 64]), 64'd682);
      checkOutput("t2_rd1", 64'(rd_log[(base + 1) % 64]), 64'd938);
      checkOutput("t2_rsp", 64'({rsp_hit, rsp_func, rsp_bucket, rsp_slot}),
                  64'({1'b1, 2'd1, 10'd938, 2'd0}));
      completeResp();

      // Matching tags but every valid bit clear: full miss.
      tbl_mem[682] = {4{12'h3BB}};
      tbl_mem[938] = {4{12'h3BB}};
      applyStimulus(ADDR_A, 1'b0, lat, base, e2, b2);
      checkOutput("t3_lat", 64'(lat), 64'd7);
      checkOutput("t3_rsp", 64'({rsp_hit, rsp_func, rsp_bucket, rsp_slot}),
                  64'({1'b0, 2'd1, 10'd938, 2'd0}));
      completeResp();

      // Slots 1 and 3 both match; slot 0 valid with a different tag.
      tbl_mem[682] = {12'hBBB, 12'h3BB, 12'hBBB, 12'hBBA};
      applyStimulus(ADDR_A, 1'b0, lat, base, e2, b2);
      checkOutput("t4_lat", 64'(lat), 64'd4);
      checkOutput("t4_rsp", 64'({rsp_hit, rsp_func, rsp_bucket, rsp_slot}),
                  64'({1'b1, 2'd0, 10'd682, 2'd1}));
      completeResp();

      // lg = 0: both probes read bucket 0, which is empty.
      configure(2'd0, 64'd1, 64'd0, 4'd0);
      applyStimulus(ADDR_A, 1'b0, lat, base, e2, b2);
      checkOutput("t5_rd0", 64'(rd_log[base % 64]), 64'd0);
      checkOutput("t5_rd1", 64'(rd_log[(base + 1) % 64]), 64'd0);
      checkOutput("t5_rsp", 64'({rsp_hit, rsp_func, rsp_bucket, rsp_slot}),
                  64'({1'b0, 2'd1, 10'd0, 2'd0}));
      completeResp();

      // Config write during READ must be dropped; a taken write would send
      // probe 2 to bucket 682 and hit in slot 1.
      applyStimulus(ADDR_A, 1'b1, lat, base, e2, b2);
      completeResp();
      applyStimulus(ADDR_A, 1'b0, lat, base, e2, b2);
      checkOutput("t5b_rd1", 64'(rd_log[(base + 1) % 64]), 64'd0);
      checkOutput("t5b_rsp", 64'({rsp_hit, rsp_func, rsp_bucket}),
                  64'({1'b0, 2'd1, 10'd0}));
      completeResp();

      // Reset restores default coefficients and lg; hold rsp_ready low.
      doReset();
      tbl_mem[682] = {12'h000, 12'hBBB, 12'h000, 12'h000};
      rsp_ready = 1'b0;
      applyStimulus(ADDR_A, 1'b0, lat, base, e2, b2);
      checkOutput("t6_lat", 64'(lat), 64'd4);
      for (int c = 0; c < 5; c++) begin
         checkOutput("t6_hold", 64'({rsp_valid, rsp_hit, rsp_func, rsp_bucket, rsp_slot, req_ready}),
                     64'({1'b1, 1'b1, 2'd0, 10'd682, 2'd2, 1'b0}));
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      completeResp();
      checkOutput("t6_release", 64'({req_ready, rsp_valid}), 64'b10);

      // Two more hits and one miss (address 0 probes empty bucket 0).
      applyStimulus(ADDR_A, 1'b0, lat, base, e2, b2);
      completeResp();
      applyStimulus(ADDR_A, 1'b0, lat, base, e2, b2);
      checkOutput("t7_hit", 64'(rsp_hit), 64'd1);
      completeResp();
      applyStimulus(64'd0, 1'b0, lat, base, e2, b2);
      checkOutput("t7_miss", 64'({rsp_hit, rsp_bucket}), 64'({1'b0, 10'd0}));
      checkOutput("t7_miss_lat", 64'(lat), 64'd7);
      completeResp();
`ifdef ADDR_LOOKUP_STATS_EN
      checkOutput("stats", {stat_hits, stat_misses}, {32'd3, 32'd1});
`else
      checkOutput("stats", {stat_hits, stat_misses}, 64'd0);
`endif

      // Reset while in CMP: no response, back to IDLE, counters cleared.
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = ADDR_A;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("t8_idle", 64'({req_ready, cfg_ready, rsp_valid}), 64'b110);
      seen_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         seen_valid = seen_valid | rsp_valid;
      end
      checkOutput("t8_no_rsp", 64'(seen_valid), 64'd0);
      checkOutput("t8_stats", {stat_hits, stat_misses}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
